sdram_port_arbiter: RTL
=======================

// Module: sdram_port_arbiter
// PURPOSE
//  Shares the single byte-wide SDRAM port (16-bit addr, 8-bit data, rd/wr/ready) between the
//  Apple-1 CPU memory path and the data_io ASCII/ROM loader. Loader bytes from ioctl_wr pulses
//  are buffered in a small FIFO. They are then written to SDRAM at LOAD_BASE+ioctl_addr. One
//  SDRAM transaction is outstanding at a time. Sits between apple1/data_io and sdram.
// PARAMETERS
//  ADDR_W      16       SDRAM byte address width
//  LOAD_BASE   16'h0000 SDRAM address of loader byte 0
//  FIFO_DEPTH  4        loader write FIFO entries (power of 2, >=2)
//  CPU_BURST   2        max consecutive CPU grants while loader FIFO non-empty
// PORTS
//  clk_sys         in   1       system clock (25 MHz)
//  reset           in   1       asynchronous, active-high reset
//  cpu_req         in   1       CPU access request (level, held until cpu_ack)
//  cpu_we          in   1       1=write, 0=read; stable while cpu_req
//  cpu_addr        in   ADDR_W  CPU byte address; stable while cpu_req
//  cpu_wdata       in   8       CPU write data; stable while cpu_req
//  cpu_rdata       out  8       read data, valid in cpu_ack cycle, held until next read ack
//  cpu_ack         out  1       1-cycle pulse: CPU transaction complete
//  ioctl_download  in   1       loader active
//  ioctl_wr        in   1       1-cycle loader byte strobe
//  ioctl_addr      in   25      loader byte offset (low ADDR_W bits used)
//  ioctl_dout      in   8       loader byte
//  load_busy       out  1       ioctl_download | FIFO non-empty | loader transaction in flight
//  load_ovf        out  1       sticky: loader byte dropped because FIFO was full
//  mem_addr        out  ADDR_W  to sdram addr
//  mem_din         out  8       to sdram din
//  mem_rd          out  1       to sdram rd
//  mem_wr          out  1       to sdram we
//  mem_dout        in   8       from sdram dout
//  mem_ready       in   1       from sdram ready; 1-cycle completion pulse
// BEHAVIOUR
//  Reset: state IDLE, FIFO empty, burst counter 0, load_ovf=0.
//  Reset: all outputs 0, including cpu_rdata=8'h00.
//  Reset mid-transaction aborts it: strobes drop immediately, FIFO flushed, no ack issued.
//  FIFO: ioctl_wr pushes {LOAD_BASE+ioctl_addr[ADDR_W-1:0] (mod 2^ADDR_W), ioctl_dout}.
//   Push when full -> byte dropped, load_ovf<=1.
//   Push and pop in the same cycle are both honoured; the count is unchanged.
//  load_ovf clears on the rising edge of ioctl_download (new download).
//  States: IDLE, CPU_ACC, LD_ACC.
//  IDLE grant decision, evaluated every cycle in IDLE:
//   1) FIFO count >= FIFO_DEPTH-1 -> LD_ACC.
//   2) else cpu_req, and (FIFO empty or burst<CPU_BURST) -> CPU_ACC, burst++.
//   3) else FIFO non-empty -> LD_ACC, burst<=0.
//   4) else stay in IDLE, burst<=0.
//  Grant cycle: mem_addr/mem_din loaded, and mem_rd or mem_wr asserted, on the next clk_sys edge.
//   Fields are loaded from the CPU port or the FIFO head; LD_ACC always asserts mem_wr.
//  mem_addr, mem_din and the strobe are held until mem_ready=1.
//  mem_ready cycle: strobe drops on the next edge, and state returns to IDLE.
//   CPU_ACC: cpu_ack pulses on that next edge; on reads cpu_rdata<=mem_dout.
//   LD_ACC: the FIFO pops.
//  Minimum gap: 1 IDLE cycle between transactions. A new grant may be issued the cycle after return.
//  CPU latency = 1 grant cycle + SDRAM latency + 1 cycle.
//  mem_ready outside CPU_ACC/LD_ACC is ignored.
//  cpu_req dropping before cpu_ack is a protocol violation; the transaction still completes and acks.
//  The CPU must deassert cpu_req in the cycle after cpu_ack, or present a new request.
//  The arbiter does not regrant on a req still high from the same access, because the ack edge returns to IDLE.
//  The apple1 block drops req on ack.
//  load_busy is combinational from the state, the FIFO count and ioctl_download.
// TESTING
//  CPU read: cpu_req, addr 16'h0300, mem_ready 3 cycles after mem_rd, mem_dout=8'hA9
//   -> mem_rd held 3 cycles, one cpu_ack, cpu_rdata=8'hA9.
//  Loader: LOAD_BASE=16'hE000, 3 ioctl_wr at offsets 0..2 with data 11,22,33, no CPU traffic
//   -> 3 mem_wr at E000/E001/E002 in order; load_busy falls after the last completion.
//  Fairness: cpu_req held continuously with FIFO holding 1 entry, CPU_BURST=2
//   -> grant order CPU, CPU, LOAD, CPU.
//  Overflow: 6 back-to-back ioctl_wr while mem_ready is withheld
//   -> 4 bytes (FIFO_DEPTH=4) are kept and written, load_ovf=1; new ioctl_download rise -> load_ovf=0.
//  Push+pop collision: ioctl_wr on the same edge as the LD_ACC mem_ready
//   -> FIFO count unchanged, byte later written.
//  Reset during CPU_ACC (mem_rd high) -> mem_rd=0 and FIFO empty immediately; no cpu_ack after release.

Source files
------------

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter
// Shares one byte-wide SDRAM port between the Apple-1 CPU memory path and the
// data_io loader. Loader bytes are queued in a small FIFO and written to
// LOAD_BASE + offset. Only one SDRAM transaction is outstanding at a time.
//
// Handshakes:
//   CPU side  : cpu_req is a level held (with cpu_we/addr/wdata stable) until
//               the single-cycle cpu_ack pulse; read data is valid in the ack
//               cycle and held until the next read completes.
//   SDRAM side: mem_addr/mem_din and exactly one of mem_rd/mem_wr are held
//               until the single-cycle mem_ready pulse; mem_ready is ignored
//               while no transaction is outstanding.
//   Loader    : ioctl_wr is a single-cycle strobe with no back-pressure; a
//               byte arriving with the FIFO full is dropped and flagged in
//               the sticky load_ovf.
module sdram_port_arbiter #(
  parameter int                ADDR_W     = 16,
  parameter logic [ADDR_W-1:0] LOAD_BASE  = '0,
  parameter int                FIFO_DEPTH = 4,
  parameter int                CPU_BURST  = 2
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic [7:0]        cpu_rdata,
  output logic              cpu_ack,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  output logic              load_busy,
  output logic              load_ovf,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_din,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic [7:0]        mem_dout,
  input  logic              mem_ready,
  output logic [1:0]        dbg_state
);

  localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W   = PTR_W + 1;
  localparam int BURST_W = (CPU_BURST > 0) ? $clog2(CPU_BURST + 1) : 1;
  localparam int ENT_W   = ADDR_W + 8;

  localparam logic [CNT_W-1:0]   FIFO_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]   LD_THRESH = CNT_W'(FIFO_DEPTH - 1);
  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(CPU_BURST);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CPU_ACC = 2'd1;
  localparam logic [1:0] S_LD_ACC  = 2'd2;

  // Offset bits above the SDRAM address width are intentionally ignored.
  logic unused_ioctl_hi;
  assign unused_ioctl_hi = ^ioctl_addr[24:ADDR_W];

  // ---------------------------------------------------------------------------
  // Loader FIFO
  // ---------------------------------------------------------------------------
  logic [ENT_W-1:0] fifo_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] fifo_cnt_q, fifo_cnt_d;

  logic             fifo_empty;
  logic             fifo_full;
  logic             push_ok;
  logic             push_drop;
  logic             pop;
  logic [ENT_W-1:0] push_entry;
  logic [ENT_W-1:0] fifo_head;

  logic [1:0]       state_q, state_d;

  assign fifo_empty = (fifo_cnt_q == '0);
  assign fifo_full  = (fifo_cnt_q == FIFO_FULL);
  // The head entry retires on the completion of its SDRAM write.
  assign pop        = (state_q == S_LD_ACC) && mem_ready;
  // A pop in the same cycle frees a slot, so a push into a full FIFO is kept.
  assign push_ok    = ioctl_wr && (!fifo_full || pop);
  assign push_drop  = ioctl_wr && fifo_full && !pop;
  assign push_entry = {LOAD_BASE + ioctl_addr[ADDR_W-1:0], ioctl_dout};
  assign fifo_head  = fifo_mem_q[rd_ptr_q];

  // FIFO pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push_ok, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + 1'b1;
      2'b01:   fifo_cnt_d = fifo_cnt_q - 1'b1;
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  // FIFO pointers; reset flushes the queue.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
    end
  end

  // FIFO storage; contents are only meaningful below the occupancy count.
  always_ff @(posedge clk_sys) begin
    if (push_ok) begin
      fifo_mem_q[wr_ptr_q] <= push_entry;
    end
  end

  // ---------------------------------------------------------------------------
  // Overflow flag
  // ---------------------------------------------------------------------------
  logic dl_q;
  logic ovf_q;

  // Sticky drop flag, cleared when a new download starts.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      dl_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      dl_q <= ioctl_download;
      if (push_drop) begin
        ovf_q <= 1'b1;
      end else if (ioctl_download && !dl_q) begin
        ovf_q <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Arbiter FSM and SDRAM request registers
  // ---------------------------------------------------------------------------
  logic [BURST_W-1:0] burst_q, burst_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [7:0]         mem_din_q, mem_din_d;
  logic               mem_rd_q, mem_rd_d;
  logic               mem_wr_q, mem_wr_d;
  logic               cpu_ack_q, cpu_ack_d;
  logic [7:0]         cpu_rdata_q, cpu_rdata_d;

  // Grant decision in IDLE and completion handling in the access states.
  always_comb begin
    state_d     = state_q;
    burst_d     = burst_q;
    mem_addr_d  = mem_addr_q;
    mem_din_d   = mem_din_q;
    mem_rd_d    = mem_rd_q;
    mem_wr_d    = mem_wr_q;
    cpu_ack_d   = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    case (state_q)
      S_IDLE: begin
        if (fifo_cnt_q >= LD_THRESH) begin
          // Nearly full FIFO: drain it ahead of the CPU to limit drops.
          state_d    = S_LD_ACC;
          mem_addr_d = fifo_head[ENT_W-1:8];
          mem_din_d  = fifo_head[7:0];
          mem_wr_d   = 1'b1;
        end else if (cpu_req && (fifo_empty || (burst_q < BURST_MAX))) begin
          state_d    = S_CPU_ACC;
          mem_addr_d = cpu_addr;
          mem_din_d  = cpu_wdata;
          mem_rd_d   = !cpu_we;
          mem_wr_d   = cpu_we;
          // Saturate so long CPU-only runs cannot wrap back to zero.
          if (burst_q != BURST_MAX) begin
            burst_d = burst_q + 1'b1;
          end
        end else if (!fifo_empty) begin
          state_d    = S_LD_ACC;
          mem_addr_d = fifo_head[ENT_W-1:8];
          mem_din_d  = fifo_head[7:0];
          mem_wr_d   = 1'b1;
          burst_d    = '0;
        end else begin
          burst_d = '0;
        end
      end
      S_CPU_ACC: begin
        if (mem_ready) begin
          state_d   = S_IDLE;
          mem_rd_d  = 1'b0;
          mem_wr_d  = 1'b0;
          cpu_ack_d = 1'b1;
          if (mem_rd_q) begin
            cpu_rdata_d = mem_dout;
          end
        end
      end
      S_LD_ACC: begin
        if (mem_ready) begin
          state_d  = S_IDLE;
          mem_rd_d = 1'b0;
          mem_wr_d = 1'b0;
        end
      end
      default: begin
        state_d  = S_IDLE;
        mem_rd_d = 1'b0;
        mem_wr_d = 1'b0;
      end
    endcase
  end

  // FSM state and registered SDRAM/CPU outputs; reset aborts any access.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      burst_q     <= '0;
      mem_addr_q  <= '0;
      mem_din_q   <= '0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      cpu_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      burst_q     <= burst_d;
      mem_addr_q  <= mem_addr_d;
      mem_din_q   <= mem_din_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
      cpu_ack_q   <= cpu_ack_d;
      cpu_rdata_q <= cpu_rdata_d;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_din   = mem_din_q;
  assign mem_rd    = mem_rd_q;
  assign mem_wr    = mem_wr_q;
  assign cpu_ack   = cpu_ack_q;
  assign cpu_rdata = cpu_rdata_q;
  assign load_ovf  = ovf_q;
  assign dbg_state = state_q;
  assign load_busy = ioctl_download || !fifo_empty || (state_q == S_LD_ACC);

endmodule
